// File: rtl/pcss_link_rx_packer.sv
// PCSS chip-to-host receive stage: parity-checked 16-bit flits are packed four
// per 64-bit word, buffered in a FWFT FIFO and emitted as an AXI-stream master.
module pcss_link_rx_packer #(
  parameter int unsigned CHIPDATA_WIDTH = 16,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ERR_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] link_data_in,
  input  logic                      link_valid,
  input  logic                      link_par,
  output logic                      link_ready,
  output logic                      link_err,
  input  logic                      tik,
  output logic [DATA_WIDTH-1:0]     M_AXIS_recv_tdata,
  output logic                      M_AXIS_recv_tvalid,
  output logic                      M_AXIS_recv_tlast,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_recv_tkeep,
  input  logic                      M_AXIS_recv_tready,
  output logic [ERR_W-1:0]          err_cnt,
  input  logic                      clr_err
);

  localparam int unsigned LANES     = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
  localparam int unsigned LANE_KEEP = CHIPDATA_WIDTH / 8;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W     = DATA_WIDTH + KEEP_W + 1;

  localparam logic [AW:0]     CNT_FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_READY_MAX = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [LANE_W:0] LANES_FULL    = (LANE_W+1)'(LANES);

  // Packer state
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  tik_dly_q, tik_dly_d;
  logic                  link_ready_q, link_ready_d;
  logic                  link_err_q, link_err_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;

  // FIFO state
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Datapath intermediates
  logic                  accept, par_ok, flit_good, flit_bad;
  logic                  flush_evt, flush_req;
  logic                  pop, can_push, push;
  logic [DATA_WIDTH-1:0] word_fill;
  logic [LANE_W:0]       lanes_fill;
  logic [KEEP_W-1:0]     push_keep;
  logic                  push_last;
  logic [ENT_W-1:0]      head;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    accept    = link_valid && link_ready_q;
    par_ok    = (link_par == ^link_data_in);
    flit_good = accept && par_ok;
    flit_bad  = accept && !par_ok;
    tik_dly_d = tik;
    flush_evt = tik_dly_q && !tik;
    flush_req = flush_evt || flush_pending_q;
    pop       = (count_q != '0) && M_AXIS_recv_tready;
    can_push  = (count_q != CNT_FULL) || pop;

    word_fill = word_q;
    if (flit_good) begin
      word_fill[32'(lane_q)*CHIPDATA_WIDTH +: CHIPDATA_WIDTH] = link_data_in;
    end
    lanes_fill = {1'b0, lane_q} + {{LANE_W{1'b0}}, flit_good};

    push_keep = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(lanes_fill)) begin
        push_keep[i*LANE_KEEP +: LANE_KEEP] = '1;
      end
    end

    // A completed word and a flush in the same cycle share one push; a flush
    // that finds no room is held pending and retried once a slot frees up.
    push            = 1'b0;
    push_last       = 1'b0;
    lane_d          = lanes_fill[LANE_W-1:0];
    word_d          = word_fill;
    flush_pending_d = 1'b0;
    if (lanes_fill == LANES_FULL) begin
      push      = 1'b1;
      push_last = flush_req;
      lane_d    = '0;
      word_d    = '0;
    end else if (flush_req && (lanes_fill != '0)) begin
      if (can_push) begin
        push      = 1'b1;
        push_last = 1'b1;
        lane_d    = '0;
        word_d    = '0;
      end else begin
        flush_pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_last, push_keep, word_fill};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    link_ready_d = (count_d <= CNT_READY_MAX) && !flush_pending_d;
    link_err_d   = flit_bad;
    err_cnt_d    = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (flit_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q          <= '0;
      word_q          <= '0;
      flush_pending_q <= 1'b0;
      tik_dly_q       <= 1'b0;
      link_ready_q    <= 1'b0;
      link_err_q      <= 1'b0;
      err_cnt_q       <= '0;
      mem_q           <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      lane_q          <= lane_d;
      word_q          <= word_d;
      flush_pending_q <= flush_pending_d;
      tik_dly_q       <= tik_dly_d;
      link_ready_q    <= link_ready_d;
      link_err_q      <= link_err_d;
      err_cnt_q       <= err_cnt_d;
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign link_ready         = link_ready_q;
  assign link_err           = link_err_q;
  assign err_cnt            = err_cnt_q;
  assign M_AXIS_recv_tvalid = (count_q != '0);
  assign M_AXIS_recv_tdata  = head[DATA_WIDTH-1:0];
  assign M_AXIS_recv_tkeep  = head[DATA_WIDTH +: KEEP_W];
  assign M_AXIS_recv_tlast  = head[ENT_W-1];

endmodule
